// File: rtl/search_pkg.sv
// Shared constants, FSM state type and the position-to-window helper for the
// DNA window search scheduler.
package search_pkg;

  localparam int DATA_W   = 1024;
  localparam int KEY_W    = 64;
  localparam int BASE_W   = 2;
  localparam int NUM_CMP  = 4;

  localparam int NUM_POS  = (DATA_W - KEY_W) / BASE_W + 1;
  localparam int POS_W    = $clog2(NUM_POS);
  localparam int SCAN_CYC = (NUM_POS + NUM_CMP - 1) / NUM_CMP;
  localparam int CNT_W    = $clog2(NUM_CMP + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Window for position p: p bases down from the MSB end of the chunk.
  function automatic logic [KEY_W-1:0] window_at(input logic [DATA_W-1:0] d,
                                                 input logic [POS_W:0]    pos);
    logic [DATA_W-1:0] v_shift;
    v_shift = d << (32'(pos) * 32'(BASE_W));
    return v_shift[DATA_W-1 -: KEY_W];
  endfunction

endpackage

// File: rtl/search_lane.sv
// Single-position comparator: flags a hit when the enabled window equals the key.
module search_lane
  import search_pkg::*;
(
  input  logic [DATA_W-1:0] i_data,
  input  logic [KEY_W-1:0]  i_key,
  input  logic [POS_W:0]    i_pos,
  input  logic              i_en,
  output logic              o_hit
);

  assign o_hit = i_en && (window_at(i_data, i_pos) == i_key);

endmodule

// File: rtl/search_scheduler.sv
// Scans every base alignment of a reference chunk against a key, NUM_CMP
// alignments per cycle, and reports hit, first matching position and hit count.
module search_scheduler
  import search_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                start_valid,
  output logic                start_ready,
  input  logic [DATA_W-1:0]   data,
  input  logic [KEY_W-1:0]    key,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                match,
  output logic [POS_W-1:0]    first_pos,
  output logic [POS_W:0]      match_count
);

  localparam logic [POS_W:0] STEP  = (POS_W+1)'(NUM_CMP);
  localparam logic [POS_W:0] LIMIT = (POS_W+1)'(NUM_POS);

  state_t              r_state;
  logic [DATA_W-1:0]   r_data;
  logic [KEY_W-1:0]    r_key;
  logic [POS_W:0]      r_pos_base;
  logic                r_start_ready;
  logic                r_busy;
  logic                r_done;
  logic                r_match;
  logic [POS_W-1:0]    r_first_pos;
  logic [POS_W:0]      r_match_count;

  logic                w_scan;
  logic [NUM_CMP-1:0]  w_hit;
  logic [POS_W:0]      w_lane_pos [NUM_CMP];
  logic [CNT_W-1:0]    w_hit_cnt;
  logic [POS_W-1:0]    w_first_off;
  logic [POS_W-1:0]    w_first_pos;
  logic                w_last_group;

  assign w_scan = (r_state == ST_SCAN);

  // Lanes beyond the last valid alignment are masked off in the final group.
  for (genvar g = 0; g < NUM_CMP; g++) begin : g_lane
    assign w_lane_pos[g] = r_pos_base + (POS_W+1)'(g);
    search_lane u_lane (
      .i_data (r_data),
      .i_key  (r_key),
      .i_pos  (w_lane_pos[g]),
      .i_en   (w_scan && (w_lane_pos[g] < LIMIT)),
      .o_hit  (w_hit[g])
    );
  end

  // Hit popcount and lowest-lane priority encode for the current group.
  always_comb begin
    w_hit_cnt   = '0;
    w_first_off = '0;
    for (int i = NUM_CMP - 1; i >= 0; i--) begin
      w_hit_cnt   = w_hit_cnt + CNT_W'(w_hit[i]);
      w_first_off = w_hit[i] ? POS_W'(i) : w_first_off;
    end
  end

  assign w_first_pos  = r_pos_base[POS_W-1:0] + w_first_off;
  assign w_last_group = ((r_pos_base + STEP) >= LIMIT);

  // Job FSM with all outputs registered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_data        <= '0;
      r_key         <= '0;
      r_pos_base    <= '0;
      r_start_ready <= 1'b1;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_match       <= 1'b0;
      r_first_pos   <= '0;
      r_match_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start_valid) begin
            r_data        <= data;
            r_key         <= key;
            r_pos_base    <= '0;
            r_match       <= 1'b0;
            r_first_pos   <= '0;
            r_match_count <= '0;
            r_start_ready <= 1'b0;
            r_busy        <= 1'b1;
            r_state       <= ST_SCAN;
          end else begin
            r_start_ready <= 1'b1;
            r_busy        <= 1'b0;
          end
        end
        ST_SCAN: begin
          if (abort) begin
            r_match       <= 1'b0;
            r_first_pos   <= '0;
            r_match_count <= '0;
            r_busy        <= 1'b0;
            r_start_ready <= 1'b1;
            r_state       <= ST_IDLE;
          end else begin
            r_match_count <= r_match_count + (POS_W+1)'(w_hit_cnt);
            if (!r_match && (w_hit != '0)) begin
              r_match     <= 1'b1;
              r_first_pos <= w_first_pos;
            end else begin
              r_match     <= r_match;
            end
            r_pos_base <= r_pos_base + STEP;
            if (w_last_group) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_SCAN;
            end
          end
        end
        ST_DONE: begin
          r_done        <= 1'b0;
          r_start_ready <= 1'b1;
          r_state       <= ST_IDLE;
        end
        default: begin
          r_done        <= 1'b0;
          r_busy        <= 1'b0;
          r_start_ready <= 1'b1;
          r_state       <= ST_IDLE;
        end
      endcase
    end
  end

  assign start_ready = r_start_ready;
  assign busy        = r_busy;
  assign done        = r_done;
  assign match       = r_match;
  assign first_pos   = r_first_pos;
  assign match_count = r_match_count;

endmodule

// File: tb/tb_search_scheduler.sv
// Randomised bench for search_scheduler against a direct position-scan model.
module tb_search_scheduler;
  import search_pkg::*;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                start_valid = 1'b0;
  logic                abort = 1'b0;
  logic [DATA_W-1:0]   data = '0;
  logic [KEY_W-1:0]    key = '0;
  logic                start_ready, busy, done, match;
  logic [POS_W-1:0]    first_pos;
  logic [POS_W:0]      match_count;

  int n_tests = 0;
  int n_fail  = 0;

  search_scheduler dut (
    .clock(clock), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
    .data(data), .key(key), .abort(abort), .busy(busy), .done(done),
    .match(match), .first_pos(first_pos), .match_count(match_count)
  );

  always #5 clock = ~clock;

  // Reference: walk all 481 alignments directly.
  function automatic void ref_search(input logic [1023:0] d, input logic [63:0] k,
                                     output logic m, output logic [8:0] fp, output logic [9:0] cnt);
    m = 1'b0; fp = 9'd0; cnt = 10'd0;
    for (int p = 0; p < 481; p++) begin
      if (d[1023 - 2*p -: 64] == k) begin
        cnt = cnt + 10'd1;
        if (!m) begin m = 1'b1; fp = 9'(p); end
      end
    end
  endfunction

  function automatic logic [1023:0] plant(input logic [1023:0] d, input logic [63:0] k, input int p);
    logic [1023:0] r;
    r = d;
    r[1023 - 2*p -: 64] = k;
    return r;
  endfunction

  task automatic rand_data(output logic [1023:0] d);
    for (int i = 0; i < 32; i++) d[i*32 +: 32] = $urandom;
  endtask

  // Offer one job; lat = cycles from accept cycle T to the done cycle.
  task automatic run_job(input logic [1023:0] d, input logic [63:0] k, input bit hold,
                         output int lat, output int busy_cyc, output int ready_hi, output int acc_wait);
    lat = -1; busy_cyc = 0; ready_hi = 0; acc_wait = 0;
    @(negedge clock);
    data = d; key = k; start_valid = 1'b1;
    while (start_ready !== 1'b1 && acc_wait < 400) begin
      @(negedge clock);
      acc_wait++;
    end
    @(posedge clock);
    for (int c = 1; c <= 400; c++) begin
      @(negedge clock);
      if (c == 1 && !hold) start_valid = 1'b0;
      if (c == 3 && hold) begin data = '0; key = '1; end
      if (busy === 1'b1) busy_cyc++;
      if (start_ready === 1'b1) ready_hi++;
      if (done === 1'b1) begin lat = c; break; end
    end
    if (hold) begin
      @(negedge clock);
      start_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #2;
    n_tests++; if (start_ready !== 1'b1) begin n_fail++; $display("FAIL reset.start_ready got %0b want 1", start_ready); end
    n_tests++; if ({busy, done, match} !== 3'b000) begin n_fail++; $display("FAIL reset.flags got %b want 000", {busy, done, match}); end
    n_tests++; if (first_pos !== 9'd0 || match_count !== 10'd0) begin n_fail++; $display("FAIL reset.results got fp=%0d cnt=%0d want 0 0", first_pos, match_count); end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_top_match();
    logic [1023:0] d; logic [63:0] k; int lat, bc, rh, aw;
    rand_data(d); k = d[1023 -: 64];
    run_job(d, k, 1'b0, lat, bc, rh, aw);
    n_tests++; if (lat !== 122) begin n_fail++; $display("FAIL top.latency got %0d want 122", lat); end
    n_tests++; if (bc !== 121) begin n_fail++; $display("FAIL top.busy_cycles got %0d want 121", bc); end
    n_tests++; if (rh !== 0) begin n_fail++; $display("FAIL top.ready_during_job got %0d want 0", rh); end
    n_tests++; if (match !== 1'b1 || first_pos !== 9'd0 || match_count !== 10'd1) begin n_fail++; $display("FAIL top.results got m=%0b fp=%0d cnt=%0d want 1 0 1", match, first_pos, match_count); end
    @(negedge clock);
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL top.done_pulse got %0b want 0", done); end
    repeat (3) @(negedge clock);
    n_tests++; if (match !== 1'b1 || first_pos !== 9'd0 || match_count !== 10'd1) begin n_fail++; $display("FAIL top.hold got m=%0b fp=%0d cnt=%0d want 1 0 1", match, first_pos, match_count); end
  endtask

  task automatic test_bottom_match();
    logic [1023:0] d; logic [63:0] k; int lat, bc, rh, aw;
    rand_data(d); k = d[63:0];
    run_job(d, k, 1'b0, lat, bc, rh, aw);
    n_tests++; if (lat !== 122) begin n_fail++; $display("FAIL bottom.latency got %0d want 122", lat); end
    n_tests++; if (match !== 1'b1 || first_pos !== 9'd480 || match_count !== 10'd1) begin n_fail++; $display("FAIL bottom.results got m=%0b fp=%0d cnt=%0d want 1 480 1", match, first_pos, match_count); end
  endtask

  task automatic test_all_zero_and_none();
    logic [1023:0] d; logic [63:0] k; int lat, bc, rh, aw;
    run_job('0, '0, 1'b0, lat, bc, rh, aw);
    n_tests++; if (match !== 1'b1 || first_pos !== 9'd0 || match_count !== 10'd481) begin n_fail++; $display("FAIL zero.results got m=%0b fp=%0d cnt=%0d want 1 0 481", match, first_pos, match_count); end
    rand_data(d); k = {$urandom, $urandom};
    run_job(d, k, 1'b0, lat, bc, rh, aw);
    n_tests++; if (match !== 1'b0 || first_pos !== 9'd0 || match_count !== 10'd0) begin n_fail++; $display("FAIL none.results got m=%0b fp=%0d cnt=%0d want 0 0 0", match, first_pos, match_count); end
  endtask

  task automatic test_two_hits_hold();
    logic [1023:0] d; logic [63:0] k; int lat, bc, rh, aw;
    rand_data(d); k = {$urandom, $urandom};
    d = plant(plant(d, k, 7), k, 300);
    run_job(d, k, 1'b1, lat, bc, rh, aw);
    n_tests++; if (lat !== 122) begin n_fail++; $display("FAIL two.latency got %0d want 122", lat); end
    n_tests++; if (rh !== 0) begin n_fail++; $display("FAIL two.ready_while_held got %0d want 0", rh); end
    n_tests++; if (match !== 1'b1 || first_pos !== 9'd7 || match_count !== 10'd2) begin n_fail++; $display("FAIL two.results got m=%0b fp=%0d cnt=%0d want 1 7 2", match, first_pos, match_count); end
    @(negedge clock);
    n_tests++; if (busy !== 1'b0 || start_ready !== 1'b1) begin n_fail++; $display("FAIL two.no_reaccept got busy=%0b rdy=%0b want 0 1", busy, start_ready); end
  endtask

  task automatic test_abort();
    logic [1023:0] d; logic [63:0] k; logic em; logic [8:0] efp; logic [9:0] ecnt;
    int w, seen, lat, bc, rh, aw;
    rand_data(d); k = {$urandom, $urandom}; d = plant(d, k, 3);
    ref_search(d, k, em, efp, ecnt);
    @(negedge clock);
    data = d; key = k; start_valid = 1'b1;
    w = 0;
    while (start_ready !== 1'b1 && w < 400) begin @(negedge clock); w++; end
    @(posedge clock);
    @(negedge clock);
    start_valid = 1'b0;
    repeat (48) @(negedge clock);
    n_tests++; if (busy !== 1'b1 || match !== 1'b1) begin n_fail++; $display("FAIL abort.pre got busy=%0b m=%0b want 1 1", busy, match); end
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    n_tests++; if ({busy, done, start_ready} !== 3'b001) begin n_fail++; $display("FAIL abort.flags got %b want 001", {busy, done, start_ready}); end
    n_tests++; if (match !== 1'b0 || first_pos !== 9'd0 || match_count !== 10'd0) begin n_fail++; $display("FAIL abort.cleared got m=%0b fp=%0d cnt=%0d want 0 0 0", match, first_pos, match_count); end
    seen = 0;
    repeat (150) begin @(negedge clock); if (done === 1'b1) seen++; end
    n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL abort.no_done got %0d want 0", seen); end
    run_job(d, k, 1'b0, lat, bc, rh, aw);
    n_tests++; if (lat !== 122) begin n_fail++; $display("FAIL abort.rerun_latency got %0d want 122", lat); end
    n_tests++; if (match !== em || first_pos !== efp || match_count !== ecnt) begin n_fail++; $display("FAIL abort.rerun got m=%0b fp=%0d cnt=%0d want %0b %0d %0d", match, first_pos, match_count, em, efp, ecnt); end
  endtask

  task automatic test_reset_mid_scan();
    logic [1023:0] d; logic [63:0] k; logic em; logic [8:0] efp; logic [9:0] ecnt;
    int w, seen, lat, bc, rh, aw;
    rand_data(d); k = {$urandom, $urandom}; d = plant(d, k, 2);
    @(negedge clock);
    data = d; key = k; start_valid = 1'b1;
    w = 0;
    while (start_ready !== 1'b1 && w < 400) begin @(negedge clock); w++; end
    @(posedge clock);
    @(negedge clock);
    start_valid = 1'b0;
    repeat (29) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    n_tests++; if ({busy, done, match, start_ready} !== 4'b0001) begin n_fail++; $display("FAIL rstmid.flags got %b want 0001", {busy, done, match, start_ready}); end
    n_tests++; if (first_pos !== 9'd0 || match_count !== 10'd0) begin n_fail++; $display("FAIL rstmid.results got fp=%0d cnt=%0d want 0 0", first_pos, match_count); end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    seen = 0;
    repeat (150) begin @(negedge clock); if (done === 1'b1 || busy === 1'b1) seen++; end
    n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL rstmid.idle_after got %0d want 0", seen); end
    ref_search(d, k, em, efp, ecnt);
    run_job(d, k, 1'b0, lat, bc, rh, aw);
    n_tests++; if (lat !== 122) begin n_fail++; $display("FAIL rstmid.rerun_latency got %0d want 122", lat); end
    n_tests++; if (match !== em || first_pos !== efp || match_count !== ecnt) begin n_fail++; $display("FAIL rstmid.rerun got m=%0b fp=%0d cnt=%0d want %0b %0d %0d", match, first_pos, match_count, em, efp, ecnt); end
  endtask

  task automatic test_back_to_back();
    logic [1023:0] d; logic [63:0] k; int lat, bc, rh, aw;
    rand_data(d); k = d[1023 - 2*100 -: 64];
    run_job(d, k, 1'b0, lat, bc, rh, aw);
    rand_data(d); k = d[1023 - 2*250 -: 64];
    run_job(d, k, 1'b0, lat, bc, rh, aw);
    n_tests++; if (aw !== 0) begin n_fail++; $display("FAIL b2b.accept_wait got %0d want 0", aw); end
    n_tests++; if (lat !== 122) begin n_fail++; $display("FAIL b2b.latency got %0d want 122", lat); end
    n_tests++; if (match !== 1'b1 || first_pos !== 9'd250 || match_count !== 10'd1) begin n_fail++; $display("FAIL b2b.results got m=%0b fp=%0d cnt=%0d want 1 250 1", match, first_pos, match_count); end
  endtask

  task automatic test_random();
    logic [1023:0] d; logic [63:0] k; logic em; logic [8:0] efp; logic [9:0] ecnt;
    int lat, bc, rh, aw, np;
    for (int j = 0; j < 8; j++) begin
      rand_data(d); k = {$urandom, $urandom};
      np = $urandom_range(0, 3);
      for (int q = 0; q < np; q++) d = plant(d, k, $urandom_range(0, 480));
      ref_search(d, k, em, efp, ecnt);
      run_job(d, k, 1'b0, lat, bc, rh, aw);
      n_tests++; if (lat !== 122) begin n_fail++; $display("FAIL rand%0d.latency got %0d want 122", j, lat); end
      n_tests++; if (match !== em || first_pos !== efp || match_count !== ecnt) begin n_fail++; $display("FAIL rand%0d.results got m=%0b fp=%0d cnt=%0d want %0b %0d %0d", j, match, first_pos, match_count, em, efp, ecnt); end
    end
  endtask

  initial begin
    test_reset();
    test_top_match();
    test_bottom_match();
    test_all_zero_and_none();
    test_two_hits_hold();
    test_abort();
    test_reset_mid_scan();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/search_scheduler.md
Name: search_scheduler

Overview:
- Sequences a full DNA window search for one job: one 1024-bit reference chunk and one 64-bit key, both 2-bit base encoded.
- Each cycle, NUM_CMP comparator lanes test consecutive base offsets. The block steps the offset base until every alignment is covered.
- Reports hit/no-hit, the first matching base position and the total match count.
- Sits between the host-side job feeder (valid/ready) and the result collector. It replaces the free-running single-window compare with a scheduled scan.

Parameters:
- DATA_W, 1024, reference chunk width in bits.
- KEY_W, 64, key width in bits.
- BASE_W, 2, bits per base; alignment step.
- NUM_CMP, 4, comparator lanes evaluated per cycle.
- Derived constant NUM_POS = (DATA_W-KEY_W)/BASE_W+1 = 481 alignments.
- Derived constant POS_W = clog2(NUM_POS) = 9.
- Derived constant SCAN_CYC = ceil(NUM_POS/NUM_CMP) = 121.

Ports:
- clock  in  1  Single clock; all state on its rising edge.
- reset  in  1  Asynchronous, active-low reset (0 = reset); deassertion is synchronous to clock.
- start_valid  in  1  Job offered.
- start_ready  out  1  Block can accept a job; high only in IDLE.
- data  in  DATA_W  Reference chunk; sampled on handshake.
- key  in  KEY_W  Search key; sampled on handshake.
- abort  in  1  Cancel the scan in progress.
- busy  out  1  High in SCAN.
- done  out  1  One-cycle pulse; results valid from this cycle.
- match  out  1  At least one alignment matched.
- first_pos  out  POS_W  Lowest matching position; 0 if none.
- match_count  out  POS_W+1  Number of matching positions, 0..481.

Behaviour:
- Reset values (async, reset=0):
  - state=IDLE; start_ready=1.
  - busy=0, done=0, match=0, first_pos=0, match_count=0.
  - Internal data/key registers and pos_base=0.
- Position mapping: position p compares data[DATA_W-1-p*BASE_W -: KEY_W] against key. Position 0 is the MSB-aligned window.
- IDLE:
  - start_ready=1.
  - On start_valid&start_ready: register data and key; clear match/first_pos/match_count; pos_base=0; go to SCAN.
  - start_valid is ignored outside IDLE.
- SCAN:
  - Lane i tests position pos_base+i.
  - Lanes with position >= NUM_POS are masked (no hit).
  - match_count += popcount(masked hits).
  - If match==0 and any hit: first_pos = position of the lowest-index hit lane; match=1. Later hits never overwrite first_pos.
  - pos_base += NUM_CMP.
  - When pos_base+NUM_CMP >= NUM_POS (last group), go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Results hold stable from done until the next job is accepted.
- Latency: handshake accepted in cycle T; SCAN occupies T+1..T+121; done=1 in T+122. A new start can be accepted in T+123.
- Throughput: one job per 123 cycles.
- Abort:
  - abort=1 in SCAN goes to IDLE on the next edge.
  - No done pulse; match, first_pos and match_count are cleared to 0.
  - abort in IDLE or DONE has no effect; DONE completes normally.
- Reset mid-scan clears everything immediately; no done pulse follows.
- Width rules:
  - match_count is POS_W+1 bits, so the 481 maximum never wraps.
  - pos_base is POS_W+1 bits so the final increment cannot overflow.

Decomposition:
- Shared package search_pkg:
  - DATA_W, KEY_W, BASE_W, NUM_CMP defaults.
  - Derived NUM_POS, POS_W, SCAN_CYC.
  - State enum {IDLE, SCAN, DONE}.
  - Position-to-slice helper function.
- One sub-module, search_lane:
  - Combinational single-position comparator.
  - Inputs: data, key, position, enable.
  - Output: hit.
  - Instantiated NUM_CMP times by generate.
- The scheduler holds the FSM, counters and the priority encoder.

Test Plan:
- Key equal to the top 64 bits of a random 1024-bit data word (no other occurrence); start at T -> done pulse at T+122, match=1, first_pos=0, match_count=1, busy high exactly 121 cycles.
- Key equal to the low 64 bits of data only -> match=1, first_pos=480 (masked-lane final group), match_count=1.
- data=0, key=0 -> match=1, first_pos=0, match_count=481. Then data with no occurrence -> match=0, first_pos=0, match_count=0.
- Key planted at positions 7 and 300 -> first_pos=7, match_count=2. start_valid held high during the scan is not accepted until start_ready returns.
- abort asserted 50 cycles into the scan -> IDLE next edge, no done, outputs 0. A fresh job then completes normally in 122 cycles.
- reset driven low asynchronously mid-scan (between edges) -> all outputs at reset values before the next edge. After release, a job is accepted and completes with correct results.
